// File: rtl/neuron_state_bank.sv
// Purpose : neuron-state register bank plus one-sweep timestep sequencer for the neuron updater.
// Latency : nr_read / host_rdata registered, 1 cycle; start->busy 1 cycle; last write->done 1 cycle.
// Backpr. : none; updater is gated via freeze, start is only sampled in IDLE.
//
// Ports   : clk/reset (sync, active-high); start/busy/done/freeze/time_index sequencing;
//           nr_addr/nr_read/nr_write/nr_we/spike_out updater port; spike_vec last-sweep spikes;
//           host_addr/host_wdata/host_we/host_rdata preload and readback port.
// Option  : NSB_SPIKE_CAPTURE_EN enables the per-sweep spike capture buffer; otherwise
//           spike_out is ignored and spike_vec is constant 0.
module neuron_state_bank #(
    parameter int NR_WIDTH = 56,
    parameter int NR_DEPTH = 16,
    localparam int ADDR_W  = (NR_DEPTH > 1) ? $clog2(NR_DEPTH) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                freeze,
    output logic                time_index,
    input  logic [ADDR_W-1:0]   nr_addr,
    output logic [NR_WIDTH-1:0] nr_read,
    input  logic [NR_WIDTH-1:0] nr_write,
    input  logic                nr_we,
    input  logic                spike_out,
    output logic [NR_DEPTH-1:0] spike_vec,
    input  logic [ADDR_W-1:0]   host_addr,
    input  logic [NR_WIDTH-1:0] host_wdata,
    input  logic                host_we,
    output logic [NR_WIDTH-1:0] host_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(NR_DEPTH - 1);

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     wr_count_q, wr_count_d;
    logic                  time_index_q, time_index_d;
    logic [NR_WIDTH-1:0]   mem_q [NR_DEPTH];
    logic [NR_WIDTH-1:0]   nr_read_q, host_rdata_q;

    logic                  nr_addr_ok, host_addr_ok;
    logic                  nr_wr_en, host_wr_en;

    // Out-of-range addresses only exist for non power-of-two depths.
    assign nr_addr_ok   = 32'(nr_addr) < 32'(NR_DEPTH);
    assign host_addr_ok = 32'(host_addr) < 32'(NR_DEPTH);

    // Each port owns the array in exactly one state, so they never collide.
    assign nr_wr_en   = (state_q == S_RUN)  && nr_we   && nr_addr_ok;
    assign host_wr_en = (state_q == S_IDLE) && host_we && host_addr_ok;

`ifdef NSB_SPIKE_CAPTURE_EN
    logic [NR_DEPTH-1:0]   cap_q, cap_d;
    logic [NR_DEPTH-1:0]   spike_vec_q, spike_vec_d;
`else
    logic                  unused_spike;
    assign unused_spike = spike_out;
`endif

    always_comb begin
        state_d      = state_q;
        wr_count_d   = wr_count_q;
        time_index_d = time_index_q;
`ifdef NSB_SPIKE_CAPTURE_EN
        cap_d        = cap_q;
        spike_vec_d  = spike_vec_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_RUN;
                    wr_count_d = '0;
`ifdef NSB_SPIKE_CAPTURE_EN
                    cap_d      = '0;
`endif
                end
            end
            S_RUN: begin
                if (nr_wr_en) begin
                    wr_count_d = wr_count_q + 1'b1;
`ifdef NSB_SPIKE_CAPTURE_EN
                    cap_d[nr_addr] = spike_out;
`endif
                    // Completion is by write count, duplicates included.
                    if (wr_count_q == LAST_CNT) begin
                        state_d      = S_DONE;
                        time_index_d = ~time_index_q;
`ifdef NSB_SPIKE_CAPTURE_EN
                        // Includes the spike of the final write.
                        spike_vec_d  = cap_d;
`endif
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wr_count_q   <= '0;
            time_index_q <= 1'b0;
`ifdef NSB_SPIKE_CAPTURE_EN
            cap_q        <= '0;
            spike_vec_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            wr_count_q   <= wr_count_d;
            time_index_q <= time_index_d;
`ifdef NSB_SPIKE_CAPTURE_EN
            cap_q        <= cap_d;
            spike_vec_q  <= spike_vec_d;
`endif
        end
    end

    // Reads sample the pre-edge array contents, giving read-first behaviour.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NR_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            nr_read_q    <= '0;
            host_rdata_q <= '0;
        end else begin
            if (nr_wr_en) begin
                mem_q[nr_addr] <= nr_write;
            end
            if (host_wr_en) begin
                mem_q[host_addr] <= host_wdata;
            end
            nr_read_q    <= nr_addr_ok   ? mem_q[nr_addr]   : '0;
            host_rdata_q <= host_addr_ok ? mem_q[host_addr] : '0;
        end
    end

    assign busy       = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign freeze     = (state_q != S_RUN);
    assign time_index = time_index_q;
    assign nr_read    = nr_read_q;
    assign host_rdata = host_rdata_q;
`ifdef NSB_SPIKE_CAPTURE_EN
    assign spike_vec  = spike_vec_q;
`else
    assign spike_vec  = '0;
`endif

endmodule

// File: tb/tb_neuron_state_bank.sv
// Purpose : scoreboarded directed bench for neuron_state_bank (depth 16, width 56).
// Latency : expectations are tagged with the cycle in which the DUT output must hold them.
// Backpr. : none; the monitor checks every cycle and flags any unexpected done pulse.
module tb_neuron_state_bank;

    localparam int W = 56;
    localparam int D = 16;

    localparam int SIG_FRZ  = 0;
    localparam int SIG_BUSY = 1;
    localparam int SIG_DONE = 2;
    localparam int SIG_TI   = 3;
    localparam int SIG_NRD  = 4;
    localparam int SIG_HRD  = 5;
    localparam int SIG_SV   = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          nr_we = 1'b0;
    logic          spike_out = 1'b0;
    logic          host_we = 1'b0;
    logic [3:0]    nr_addr = '0;
    logic [3:0]    host_addr = '0;
    logic [W-1:0]  nr_write = '0;
    logic [W-1:0]  host_wdata = '0;
    logic          busy, done, freeze, time_index;
    logic [W-1:0]  nr_read, host_rdata;
    logic [D-1:0]  spike_vec;

    neuron_state_bank #(.NR_WIDTH(W), .NR_DEPTH(D)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .freeze(freeze), .time_index(time_index), .nr_addr(nr_addr),
        .nr_read(nr_read), .nr_write(nr_write), .nr_we(nr_we),
        .spike_out(spike_out), .spike_vec(spike_vec), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_we(host_we), .host_rdata(host_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          sig;
        logic [63:0] val;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [W-1:0] model_mem [D];
    logic        model_ti = 1'b0;
    bit          done_chk;

    function automatic logic [63:0] actual(input int sig);
        case (sig)
            SIG_FRZ:  return 64'(freeze);
            SIG_BUSY: return 64'(busy);
            SIG_DONE: return 64'(done);
            SIG_TI:   return 64'(time_index);
            SIG_NRD:  return 64'(nr_read);
            SIG_HRD:  return 64'(host_rdata);
            SIG_SV:   return 64'(spike_vec);
            default:  return 64'hDEAD_BEEF;
        endcase
    endfunction

    function automatic logic [63:0] sv_exp(input logic [15:0] v);
`ifdef NSB_SPIKE_CAPTURE_EN
        return 64'(v);
`else
        return (v != 16'h0) ? 64'h0 : 64'h0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int dc, input int sig, input logic [63:0] v, input string nm);
        exp_t e;
        e.cyc  = cyc + dc;
        e.sig  = sig;
        e.val  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    // Monitor: pops every expectation due this cycle; done must be 0 unless expected.
    always @(negedge clk) begin
        logic [63:0] a;
        done_chk = 1'b0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                n_checks++;
                a = actual(sb[i].sig);
                if (sb[i].sig == SIG_DONE) done_chk = 1'b1;
                if (a !== sb[i].val) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d actual=%0h required=%0h", sb[i].name, cyc, a, sb[i].val);
                end
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                n_fail++;
                $display("FAIL %s stale expectation cyc=%0d", sb[i].name, sb[i].cyc);
                sb.delete(i);
            end
        end
        if (!done_chk) begin
            n_checks++;
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL spurious_done cyc=%0d actual=%b required=0", cyc, done);
            end
        end
    end

    task automatic expect_reset_vals();
        expect_at(1, SIG_FRZ,  64'd1, "rst_freeze");
        expect_at(1, SIG_BUSY, 64'd0, "rst_busy");
        expect_at(1, SIG_DONE, 64'd0, "rst_done");
        expect_at(1, SIG_TI,   64'd0, "rst_time_index");
        expect_at(1, SIG_NRD,  64'd0, "rst_nr_read");
        expect_at(1, SIG_HRD,  64'd0, "rst_host_rdata");
        expect_at(1, SIG_SV,   64'd0, "rst_spike_vec");
    endtask

    task automatic clear_model();
        for (int i = 0; i < D; i++) model_mem[i] = '0;
        model_ti = 1'b0;
    endtask

    task automatic readback_all();
        for (int i = 0; i < D; i++) begin
            host_addr = 4'(i);
            expect_at(1, SIG_HRD, 64'(model_mem[i]), "readback");
            step();
        end
    endtask

    // mode 0: addr k, data k+1, spike on odd k
    // mode 1: two writes to addr 5 (9 then 10), then addr k data 0x100+k, spike only at k=2
    // mode 2: addr k, data 0x200+k, spike always
    task automatic sweep(input int mode, input int n, input logic [15:0] sv_on, input bit do_reset);
        int a;
        logic [W-1:0] d;
        logic s;
        start = 1'b1;
        expect_at(1, SIG_BUSY, 64'd1, "start_busy");
        expect_at(1, SIG_FRZ,  64'd0, "start_freeze");
        step();
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            case (mode)
                0: begin a = k; d = W'(k + 1); s = k[0]; end
                1: begin
                    a = (k < 2) ? 5 : k;
                    d = (k == 0) ? W'(9) : (k == 1) ? W'(10) : W'(32'h100 + k);
                    s = (k == 2);
                end
                default: begin a = k; d = W'(32'h200 + k); s = 1'b1; end
            endcase
            nr_we      = 1'b1;
            nr_addr    = 4'(a);
            nr_write   = d;
            spike_out  = s;
            start      = (k == 1);
            host_we    = (k == 5);
            host_addr  = 4'd0;
            host_wdata = W'(32'hDEAD);
            expect_at(1, SIG_NRD, 64'(model_mem[a]), "sweep_nr_read");
            model_mem[a] = d;
            if (k == D - 1) begin
                model_ti = ~model_ti;
                expect_at(1, SIG_DONE, 64'd1, "done_pulse");
                expect_at(1, SIG_FRZ,  64'd1, "done_freeze");
                expect_at(1, SIG_BUSY, 64'd0, "done_busy");
                expect_at(1, SIG_TI,   64'(model_ti), "done_time_index");
                expect_at(1, SIG_SV,   sv_exp(sv_on), "done_spike_vec");
            end else begin
                expect_at(1, SIG_BUSY, 64'd1, "run_busy");
            end
            step();
        end
        nr_we = 1'b0; start = 1'b0; host_we = 1'b0; spike_out = 1'b0;
        if (do_reset) begin
            reset = 1'b1;
            expect_reset_vals();
            step();
            reset = 1'b0;
            clear_model();
        end else begin
            start = 1'b1;
            expect_at(1, SIG_BUSY, 64'd0, "done_start_ignored");
            expect_at(1, SIG_FRZ,  64'd1, "idle_freeze");
            step();
            start = 1'b0;
            expect_at(1, SIG_BUSY, 64'd0, "still_idle");
            step();
        end
    endtask

    initial begin
        clear_model();
        reset = 1'b1;
        expect_reset_vals();
        step();
        step();
        reset = 1'b0;

        // Host preload in IDLE, read-first on the host port.
        host_we = 1'b1; host_addr = 4'd3; host_wdata = W'(8'hA5);
        expect_at(1, SIG_HRD, 64'd0, "host_read_first");
        step();
        host_we = 1'b0;
        model_mem[3] = W'(8'hA5);
        expect_at(1, SIG_HRD, 64'hA5, "host_rd_a5");
        expect_at(1, SIG_FRZ, 64'd1, "idle_freeze");
        expect_at(1, SIG_TI,  64'd0, "idle_time_index");
        step();

        // Updater writes are ignored in IDLE.
        nr_we = 1'b1; nr_addr = 4'd4; nr_write = W'(8'h44);
        expect_at(1, SIG_NRD, 64'd0, "idle_nr_read");
        step();
        nr_we = 1'b0;
        expect_at(1, SIG_NRD, 64'd0, "idle_nrwe_ignored");
        step();

        sweep(0, D, 16'hAAAA, 1'b0);
        readback_all();

        host_we = 1'b1; host_addr = 4'd5; host_wdata = W'(7);
        step();
        host_we = 1'b0;
        model_mem[5] = W'(7);
        sweep(1, D, 16'h0004, 1'b0);
        readback_all();

        sweep(0, D, 16'hAAAA, 1'b0);
        sweep(2, 8, 16'h0000, 1'b1);
        readback_all();

        step();
        step();
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/neuron_state_bank.md
# neuron_state_bank

Neuron-state register bank and timestep sequencer serving the neuron update datapath. Holds NR_DEPTH packed neuron words and answers the updater's read-address and write-back traffic. Gates the updater with `freeze`, publishes the timestep parity `time_index`, and captures per-neuron spikes. Sits between the network controller (start/done, host preload/readback) and `neuron_update_module`.

## Interface
- NR_WIDTH, 56, bits per packed neuron state word
- NR_DEPTH, 16, neurons in the bank; ADDR_W = $clog2(NR_DEPTH)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request one timestep sweep (sampled in IDLE only)
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at end of sweep
- freeze  out  1  high when the updater must hold (IDLE, DONE)
- time_index  out  1  timestep parity; toggles once per completed sweep
- nr_addr  in  ADDR_W  updater read/write address
- nr_read  out  NR_WIDTH  registered read data for nr_addr
- nr_write  in  NR_WIDTH  updater write-back data
- nr_we  in  1  updater write enable
- spike_out  in  1  updater spike for the word being written
- spike_vec  out  NR_DEPTH  spikes of last completed sweep, bit i = neuron i
- host_addr  in  ADDR_W  preload/readback address
- host_wdata  in  NR_WIDTH  preload data
- host_we  in  1  preload write enable
- host_rdata  out  NR_WIDTH  registered readback data

## Operation
- Storage: NR_DEPTH x NR_WIDTH flop array; reset clears every word to 0.
- FSM states IDLE, RUN, DONE; reset -> IDLE.
- IDLE: freeze=1; host_we writes mem[host_addr]; nr_we ignored; start=1 -> RUN, wr_count<=0, spike capture buffer cleared.
- RUN: freeze=0, busy=1; nr_we writes mem[nr_addr]<=nr_write, wr_count increments; host_we ignored; start ignored. When nr_we accepted with wr_count==NR_DEPTH-1 -> DONE.
- DONE (one cycle): done=1, freeze=1, time_index toggled, spike_vec loaded from capture buffer; -> IDLE.
- Reads: nr_read<=mem[nr_addr] and host_rdata<=mem[host_addr] every cycle in all states; read-first (same-cycle write to same address returns old word).
- nr_addr or host_addr >= NR_DEPTH (non power-of-two depth): read returns 0; write dropped and not counted.
- Duplicate writes to one address in a sweep each count toward wr_count; sweep completeness is by count, not coverage.
- Reset mid-RUN: FSM -> IDLE, memory cleared, time_index 0, spike_vec 0; partial sweep discarded.

## Timing
- Reset values: busy 0, done 0, freeze 1, time_index 0, nr_read 0, host_rdata 0, spike_vec 0.
- Read latency 1 cycle for both ports.
- start high at cycle t in IDLE -> busy=1, freeze=0 at t+1.
- Final counted nr_we at cycle w -> done=1, freeze=1, new time_index, new spike_vec at w+1; busy=0 at w+1; IDLE at w+2.
- start at w+1 (DONE) ignored; earliest accepted at w+2.
- Minimum sweep: NR_DEPTH+2 cycles start-to-IDLE.

## Configuration
- NSB_SPIKE_CAPTURE_EN defined: each accepted nr_we in RUN sets capture bit [nr_addr] to spike_out; spike_vec updated in DONE as above.
- Not defined: spike_out unused, no capture buffer, spike_vec tied to 0; all other behaviour identical.

## Test plan
- Reset then idle: freeze=1, time_index=0, nr_read=0; host_we writes 0xA5 at addr 3, host_rdata for addr 3 reads 0xA5 one cycle later.
- Full sweep, NR_DEPTH=16: start, 16 writes addr i data i+1, spike_out=1 on odd i -> done pulse one cycle after 16th write, time_index=1, spike_vec=0xAAAA, mem[i]=i+1.
- Read-first: addr 5 holds 7, same-cycle nr_we addr 5 data 9 -> nr_read=7 next cycle, 9 the cycle after.
- Ignored inputs: start during RUN and DONE, nr_we during IDLE, host_we during RUN -> no state or memory change, wr_count unaffected.
- Reset after 8 of 16 writes -> IDLE next cycle, freeze=1, all words 0, spike_vec 0, no done pulse.
- Macro off: full sweep with spike_out=1 always -> spike_vec stays 0, done and time_index as in scenario 2.
